// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port, the packed-beat master port and the
// status/debug signals of fifo_rd_packer.
//
// Handshake: a beat on m_data/m_half moves when m_valid & m_ready are both
// high on a rising clk edge. While m_valid=1 and m_ready=0 the beat
// (m_data, m_half) is held stable. m_valid never depends on m_ready.
interface fifo_rd_packer_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                    fifo_empty;
  logic [FIFO_WIDTH-1:0]   fifo_data_out;
  logic                    fifo_underflow;
  logic                    fifo_rd_en;
  logic [2*FIFO_WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_half;
  logic                    m_ready;
  logic                    flush;
  logic                    flush_done;
  logic                    err_underflow;
  logic [15:0]             beat_count;
  logic                    dbg_flush_wait;  // FSM state: 1 = FLUSH_WAIT

  // Packer side
  modport master (
    input  fifo_empty, fifo_data_out, fifo_underflow, m_ready, flush,
    output fifo_rd_en, m_data, m_valid, m_half, flush_done, err_underflow,
           beat_count, dbg_flush_wait
  );

  // FIFO / sink side
  modport slave (
    output fifo_empty, fifo_data_out, fifo_underflow, m_ready, flush,
    input  fifo_rd_en, m_data, m_valid, m_half, flush_done, err_underflow,
           beat_count, dbg_flush_wait
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pulls 16-bit words from a FIFO without underflow,
// pairs them into 32-bit beats (first word in the low half) and offers the
// beats on a valid/ready port. A flush drains a held odd word as a half beat.
module fifo_rd_packer #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  fifo_rd_packer_if.master  bus
);

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_FLUSH_WAIT = 1'b1
  } state_t;

  state_t                  r_state;
  logic [FIFO_WIDTH-1:0]   r_lo;
  logic                    r_lo_valid;
  logic                    r_inflight;
  logic [2*FIFO_WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_half;
  logic                    r_flush_done;
  logic                    r_err;
  logic [15:0]             r_beat_count;

  logic [1:0] w_c;
  logic       w_rd_en;
  logic       w_accept;
  logic       w_form;
  logic       w_exit;
  logic       w_half_load;

  // Words held or on their way back: 0..2.
  assign w_c = {1'b0, r_lo_valid} + {1'b0, r_inflight};

  // Only c==1 can produce a beat next cycle, so that is the only case that
  // needs the output register to be free after this edge.
  assign w_rd_en = ~rst & ~bus.fifo_empty & (r_state == ST_RUN) & ~bus.flush &
                   ((w_c != 2'd1) | ~r_valid | bus.m_ready);

  assign w_accept    = r_valid & bus.m_ready;
  assign w_form      = r_inflight & r_lo_valid;
  assign w_exit      = (r_state == ST_FLUSH_WAIT) & ~r_inflight &
                       (~r_valid | bus.m_ready);
  assign w_half_load = w_exit & r_lo_valid;

  // Flush sequencing: wait out in-flight reads and a busy output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (bus.flush) r_state <= ST_FLUSH_WAIT;
        end
        ST_FLUSH_WAIT: begin
          if (w_exit) begin
            r_state      <= ST_RUN;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Word pairing, output register, beat counter and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo         <= '0;
      r_lo_valid   <= 1'b0;
      r_inflight   <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_half       <= 1'b0;
      r_err        <= 1'b0;
      r_beat_count <= '0;
    end else begin
      r_inflight <= w_rd_en;

      if (r_inflight & ~r_lo_valid) begin
        r_lo       <= bus.fifo_data_out;
        r_lo_valid <= 1'b1;
      end else if (w_form | w_half_load) begin
        r_lo_valid <= 1'b0;
      end

      // The read rule guarantees the register is free when a beat loads.
      if (w_form) begin
        r_data  <= {bus.fifo_data_out, r_lo};
        r_half  <= 1'b0;
        r_valid <= 1'b1;
      end else if (w_half_load) begin
        r_data  <= {{FIFO_WIDTH{1'b0}}, r_lo};
        r_half  <= 1'b1;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_accept)           r_beat_count <= r_beat_count + 16'd1;
      if (bus.fifo_underflow) r_err        <= 1'b1;
    end
  end

  assign bus.fifo_rd_en     = w_rd_en;
  assign bus.m_data         = r_data;
  assign bus.m_valid        = r_valid;
  assign bus.m_half         = r_half;
  assign bus.flush_done     = r_flush_done;
  assign bus.err_underflow  = r_err;
  assign bus.beat_count     = r_beat_count;
  assign bus.dbg_flush_wait = (r_state == ST_FLUSH_WAIT);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a small FIFO model feeds the read port, a
// per-cycle scoreboard checks beat order, no-overwrite and no read-on-empty.
module tb_fifo_rd_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_packer_if bus ();

  fifo_rd_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- FIFO model ----------------
  logic [15:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  fifo_cnt;
  logic        fifo_clr;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_cnt       = wr_ptr - rd_ptr;

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      bus.fifo_data_out <= mem[rd_ptr];
      rd_ptr            <= rd_ptr + 8'd1;
    end
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  int          rd_count = 0;
  logic [32:0] exp_q[$];   // {half, data}
  logic        held_v = 1'b0;
  logic [31:0] held_d;
  logic        held_h;

  // One clock cycle: sample at the falling edge, then let the rising edge pass.
  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    if (rst) begin
      held_v = 1'b0;
      if (bus.fifo_rd_en) begin
        total++;
        bad++;
        $display("FAIL rd_en_in_reset: fifo_rd_en=1 required 0");
      end
    end else begin
      if (bus.fifo_rd_en) begin
        rd_count++;
        total++;
        if (bus.fifo_empty) begin
          bad++;
          $display("FAIL rd_on_empty: fifo_rd_en=1 while fifo_empty=1");
        end
      end
      if (held_v) begin
        total++;
        if (!(bus.m_valid && bus.m_data === held_d && bus.m_half === held_h)) begin
          bad++;
          $display("FAIL stall_overwrite: got v=%0b d=%h h=%0b required v=1 d=%h h=%0b",
                   bus.m_valid, bus.m_data, bus.m_half, held_d, held_h);
        end
      end
      held_v = bus.m_valid && !bus.m_ready;
      held_d = bus.m_data;
      held_h = bus.m_half;
      if (bus.m_valid && bus.m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got d=%h h=%0b required none",
                   bus.m_data, bus.m_half);
        end else begin
          e = exp_q.pop_front();
          if ({bus.m_half, bus.m_data} !== e) begin
            bad++;
            $display("FAIL beat: got h=%0b d=%h required h=%0b d=%h",
                     bus.m_half, bus.m_data, e[32], e[31:0]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !bus.fifo_empty) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || !bus.fifo_empty) begin
      bad++;
      $display("FAIL drain_timeout: pending beats=%0d fifo_cnt=%0d required 0/0",
               exp_q.size(), fifo_cnt);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (bus.m_valid !== 1'b0 || bus.m_half !== 1'b0 || bus.m_data !== 32'h0 ||
        bus.flush_done !== 1'b0 || bus.err_underflow !== 1'b0 ||
        bus.beat_count !== 16'h0 || bus.dbg_flush_wait !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: v=%0b h=%0b d=%h fd=%0b err=%0b cnt=%0d st=%0b required all 0",
               bus.m_valid, bus.m_half, bus.m_data, bus.flush_done,
               bus.err_underflow, bus.beat_count, bus.dbg_flush_wait);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int rd0 = rd_count;
    bus.m_ready = 1'b1;
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    exp_q.push_back({1'b0, 32'h22221111});
    exp_q.push_back({1'b0, 32'h44443333});
    wait_drain(30);
    repeat (4) step();
    total++;
    if (bus.beat_count !== 16'd2) begin
      bad++;
      $display("FAIL basic_count: beat_count=%0d required 2", bus.beat_count);
    end
    total++;
    if (rd_count - rd0 != 4) begin
      bad++;
      $display("FAIL basic_reads: reads=%0d required 4", rd_count - rd0);
    end
  endtask

  task automatic test_back_to_back_stall();
    int rd0 = rd_count;
    logic [15:0] c0 = bus.beat_count;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    for (int k = 0; k < 4; k++)
      exp_q.push_back({1'b0, 16'h0100 + 16'(2*k+1), 16'h0100 + 16'(2*k)});
    repeat (20) step();
    total++;
    if (rd_count - rd0 != 3) begin
      bad++;
      $display("FAIL stall_reads: reads=%0d required 3", rd_count - rd0);
    end
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h01010100) begin
      bad++;
      $display("FAIL stall_beat: v=%0b d=%h required v=1 d=01010100",
               bus.m_valid, bus.m_data);
    end
    bus.m_ready = 1'b1;
    wait_drain(40);
    repeat (3) step();
    total++;
    if (rd_count - rd0 != 8 || bus.beat_count - c0 != 16'd4) begin
      bad++;
      $display("FAIL stall_release: reads=%0d beats=%0d required 8 and 4",
               rd_count - rd0, bus.beat_count - c0);
    end
  endtask

  task automatic test_flush_odd();
    logic seen = 1'b0;
    bus.m_ready = 1'b1;
    push(16'h000A); push(16'h000B); push(16'h000C);
    exp_q.push_back({1'b0, 32'h000B000A});
    exp_q.push_back({1'b1, 32'h0000000C});
    repeat (8) step();
    total++;
    if (exp_q.size() != 1 || bus.m_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_pre: pending=%0d v=%0b required 1 and 0",
               exp_q.size(), bus.m_valid);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (bus.flush_done) begin
        seen = 1'b1;
        total++;
        if (!(bus.m_valid && bus.m_half && bus.m_data === 32'h0000000C)) begin
          bad++;
          $display("FAIL flush_half_beat: v=%0b h=%0b d=%h required 1 1 0000000c",
                   bus.m_valid, bus.m_half, bus.m_data);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL flush_done_timeout: flush_done=0 required 1");
    end
    step();
    total++;
    if (bus.flush_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_done_pulse: flush_done=%0b required 0", bus.flush_done);
    end
    wait_drain(10);
  endtask

  task automatic test_flush_empty();
    bus.m_ready = 1'b1;
    bus.flush   = 1'b1;
    step();
    bus.flush   = 1'b0;
    total++;
    if (bus.dbg_flush_wait !== 1'b1 || bus.flush_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty_wait: st=%0b fd=%0b required 1 0",
               bus.dbg_flush_wait, bus.flush_done);
    end
    step();
    total++;
    if (bus.flush_done !== 1'b1 || bus.m_valid !== 1'b0 || bus.dbg_flush_wait !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty_done: fd=%0b v=%0b st=%0b required 1 0 0",
               bus.flush_done, bus.m_valid, bus.dbg_flush_wait);
    end
    repeat (3) step();
  endtask

  task automatic test_underflow();
    bus.fifo_underflow = 1'b1;
    step();
    bus.fifo_underflow = 1'b0;
    step();
    total++;
    if (bus.err_underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_set: err=%0b required 1", bus.err_underflow);
    end
    repeat (5) step();
    total++;
    if (bus.err_underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_sticky: err=%0b required 1", bus.err_underflow);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus.err_underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clear: err=%0b required 0", bus.err_underflow);
    end
  endtask

  task automatic test_reset_midstream();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h5000 + 16'(i));
    repeat (10) step();
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h50015000) begin
      bad++;
      $display("FAIL midreset_stall: v=%0b d=%h required 1 50015000",
               bus.m_valid, bus.m_data);
    end
    rst      = 1'b1;
    fifo_clr = 1'b1;
    step();
    total++;
    if (bus.m_valid !== 1'b0 || bus.m_half !== 1'b0 || bus.m_data !== 32'h0 ||
        bus.beat_count !== 16'h0 || bus.flush_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear: v=%0b h=%0b d=%h cnt=%0d fd=%0b required all 0",
               bus.m_valid, bus.m_half, bus.m_data, bus.beat_count, bus.flush_done);
    end
    rst      = 1'b0;
    fifo_clr = 1'b0;
    exp_q.delete();
    bus.m_ready = 1'b1;
    push(16'h6001); push(16'h6002);
    exp_q.push_back({1'b0, 32'h60026001});
    wait_drain(20);
    repeat (3) step();
    total++;
    if (bus.beat_count !== 16'd1 || bus.m_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_refill: cnt=%0d v=%0b required 1 0",
               bus.beat_count, bus.m_valid);
    end
  endtask

  task automatic test_stress();
    logic        pend_v = 1'b0;
    logic [15:0] pend_w = 16'h0;
    logic [15:0] w;
    logic        seen = 1'b0;
    int          pushes = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if (fifo_cnt < 8 && pushes < 151 && $urandom_range(0, 1) == 1) begin
        w = 16'($urandom_range(0, 65535));
        push(w);
        pushes++;
        if (pend_v) begin
          exp_q.push_back({1'b0, w, pend_w});
          pend_v = 1'b0;
        end else begin
          pend_w = w;
          pend_v = 1'b1;
        end
      end
      step();
    end
    bus.m_ready = 1'b1;
    wait_drain(60);
    repeat (3) step();
    if (pend_v) exp_q.push_back({1'b1, 16'h0, pend_w});
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.flush_done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL stress_flush_timeout: flush_done=0 required 1");
    end
    wait_drain(10);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst                = 1'b1;
    fifo_clr           = 1'b0;
    bus.m_ready        = 1'b0;
    bus.flush          = 1'b0;
    bus.fifo_underflow = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back_stall();
    test_flush_odd();
    test_flush_empty();
    test_underflow();
    test_reset_midstream();
    test_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Downstream read-side stage for the 16-bit × 8 FIFO. Pulls words from the FIFO read port without ever underflowing it, pairs consecutive words into 32-bit beats, and presents them on a valid/ready master port with full backpressure. A flush request drains a dangling odd word as a half-filled beat. It shares the FIFO's clock.

## Interface
Parameters:
- FIFO_WIDTH, 16, FIFO word width; output beat is 2*FIFO_WIDTH.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- fifo_empty  input  1  FIFO empty flag
- fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_underflow  input  1  FIFO underflow flag
- fifo_rd_en  output  1  FIFO read strobe (combinational)
- m_data  output  2*FIFO_WIDTH  packed beat; first word in [15:0], second in [31:16]
- m_valid  output  1  beat valid
- m_half  output  1  beat carries only [15:0]; [31:16] = 0
- m_ready  input  1  sink accepts beat when m_valid & m_ready
- flush  input  1  one-cycle request to drain a held odd word
- flush_done  output  1  one-cycle pulse when the flush completes
- err_underflow  output  1  sticky; set if fifo_underflow is ever seen high
- beat_count  output  16  beats accepted by sink, wraps 16'hFFFF -> 0

## Operation
- Internal state: lo_reg/lo_valid (held first half), inflight (read issued last cycle), output register (m_data/m_valid/m_half), FSM {RUN, FLUSH_WAIT}.
- c = lo_valid + inflight (0..2).
- fifo_rd_en = ~fifo_empty & (state==RUN) & ~flush & (c != 1 | ~m_valid | m_ready).
- Returned word (inflight=1): if lo_valid=0, load lo_reg, set lo_valid; else form beat {fifo_data_out, lo_reg}, m_half=0, load the output register, clear lo_valid.
- The read rule guarantees the output register is free whenever a beat forms. Overwriting an un-accepted beat is a design error; the bench asserts this never happens.
- Output register clears m_valid on acceptance unless a new beat loads the same cycle.
- flush in RUN: go to FLUSH_WAIT. No reads are issued while in FLUSH_WAIT.
- FLUSH_WAIT exit condition: inflight=0 and the output register is free (~m_valid | m_ready).
  - On exit, if lo_valid=1: load beat {16'h0, lo_reg} with m_half=1 and clear lo_valid.
  - On exit, pulse flush_done (the same cycle the half beat loads, if any) and return to RUN.
- flush while already in FLUSH_WAIT is ignored.
- A word returning while in FLUSH_WAIT pairs normally. It may complete a full beat, in which case no half beat is produced.
- beat_count increments on each m_valid & m_ready.
- err_underflow sets on fifo_underflow=1 and clears only on rst.

## Timing
- Reset (rst sampled high): m_valid=0, m_half=0, m_data=0, flush_done=0, err_underflow=0, beat_count=0, lo_valid=0, inflight=0, state=RUN.
- fifo_rd_en is forced 0 during rst.
- A word whose read was in flight at reset is dropped.
- Read latency: fifo_rd_en at cycle t -> data sampled at t+1.
- Beat latency: second half-word's rd_en at t -> m_valid at t+2 (registered).
- Throughput with m_ready=1 and FIFO non-empty: one read per cycle, one beat every 2 cycles.
- Stall: m_valid held with m_ready=0 -> m_data, m_half stable. At most one extra word is read, held in lo_reg.
- Empty: no fifo_rd_en while fifo_empty=1, so fifo_underflow never occurs under correct integration.
- Simultaneous flush and a returning word: the word is absorbed first, then the flush proceeds.
- Simultaneous acceptance and a new beat load: m_valid stays 1 and the new data appears next cycle.

## Test plan
- Write 4 words 0x1111, 0x2222, 0x3333, 0x4444, hold m_ready=1 -> beats 0x22221111 then 0x44443333, m_half=0, beat_count=2, no fifo_rd_en once empty.
- Write 8 words, hold m_ready=0 for 20 cycles -> exactly 3 reads issued (first beat held, one word in lo_reg); release -> 4 ordered beats and no lost words.
- Write 3 words (0xA, 0xB, 0xC), then pulse flush -> beat 0x000B000A, then beat 0x0000000C with m_half=1, flush_done coincident with the half beat loading.
- Flush with lo_valid=0 and FIFO empty -> flush_done the next cycle, no beat.
- Assert rst mid-stream with a beat stalled -> all outputs 0 next cycle. Refill with 2 words -> the correct pair is emitted.
- Drive fifo_underflow=1 for one cycle -> err_underflow=1 and remains set until rst. Also run a random m_ready / FIFO-fill stress with a scoreboard checking order and the no-overwrite assertion.
